// File: rtl/lin_norm_pkg.sv
// Shared constants for the float->fixed linearizer/normalizer: ROM address
// width, table exponent range and shift-LUT sequencer state encoding.
package lin_norm_pkg;

    localparam int ADRS_W = 5;
    localparam int E_MIN  = -32;
    localparam int E_MAX  = 31;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

endpackage

// File: rtl/shift_lut_sequencer_if.sv
// Request / result / ROM signal bundle of the shift-LUT sequencer.
// Handshakes: a transfer happens on a rising CLK edge where VALID & READY are
// both 1; a source holds VALID and its payload unchanged until that edge.
interface shift_lut_sequencer_if #(
    parameter int P  = 5,
    parameter int EW = 8
) ();
    import lin_norm_pkg::*;

    logic              IN_VALID;
    logic              IN_READY;
    logic [EW-1:0]     EXP;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [P-1:0]      SHIFT_AMT;
    logic              SHIFT_LEFT;
    logic              SAT;
    logic              EN_ROM1;
    logic [ADRS_W-1:0] ADRS;
    logic [P-1:0]      LUT_D;

    // Upstream requester, downstream consumer and ROM together
    modport master (
        output IN_VALID, EXP, OUT_READY, LUT_D,
        input  IN_READY, OUT_VALID, SHIFT_AMT, SHIFT_LEFT, SAT, EN_ROM1, ADRS
    );

    // The sequencer itself
    modport slave (
        input  IN_VALID, EXP, OUT_READY, LUT_D,
        output IN_READY, OUT_VALID, SHIFT_AMT, SHIFT_LEFT, SAT, EN_ROM1, ADRS
    );

endinterface

// File: rtl/shift_lut_addr_dec.sv
// Exponent range check and ROM address / shift direction decode.
// Shared with the fixed->float path, so it stays purely combinational.
module shift_lut_addr_dec
    import lin_norm_pkg::*;
#(
    parameter int EW   = 8,
    parameter int BIAS = 127
) (
    input  logic [EW-1:0]     exp_val,
    output logic [ADRS_W-1:0] adrs,
    output logic              shift_left,
    output logic              sat
);

    localparam logic signed [EW+1:0] E_LO   = (EW+2)'(E_MIN);
    localparam logic signed [EW+1:0] E_HI   = (EW+2)'(E_MAX);
    localparam logic signed [EW+1:0] BIAS_S = (EW+2)'(BIAS);

    logic signed [EW+1:0] e;

    always_comb begin
        e          = $signed({2'b00, exp_val}) - BIAS_S;
        sat        = (e < E_LO) || (e > E_HI);
        shift_left = ~e[EW+1];
        // -e-1 is the bitwise complement in two's complement
        adrs       = e[EW+1] ? ~e[ADRS_W-1:0] : e[ADRS_W-1:0];
    end

endmodule

// File: rtl/shift_lut_sequencer.sv
// Sequences one shift-amount ROM lookup per accepted exponent and holds the
// result on a valid/ready port; out-of-range exponents skip the ROM.
module shift_lut_sequencer
    import lin_norm_pkg::*;
#(
    parameter int P       = 5,
    parameter int EW      = 8,
    parameter int BIAS    = 127,
    parameter int LUT_LAT = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    shift_lut_sequencer_if.slave bus,
    output logic [1:0]           state_dbg
);

    localparam logic [1:0] CNT_LOAD = 2'(LUT_LAT - 1);

    logic [1:0]        state;
    logic [1:0]        lat_cnt;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [P-1:0]      shift_amt_r;
    logic              shift_left_r;
    logic              sat_r;
    logic              en_rom_r;
    logic [ADRS_W-1:0] adrs_r;

    logic [ADRS_W-1:0] dec_adrs;
    logic              dec_left;
    logic              dec_sat;

    shift_lut_addr_dec #(
        .EW   (EW),
        .BIAS (BIAS)
    ) u_addr_dec (
        .exp_val    (bus.EXP),
        .adrs       (dec_adrs),
        .shift_left (dec_left),
        .sat        (dec_sat)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= ST_IDLE;
            lat_cnt      <= 2'd0;
            in_ready_r   <= 1'b0;
            out_valid_r  <= 1'b0;
            shift_amt_r  <= '0;
            shift_left_r <= 1'b0;
            sat_r        <= 1'b0;
            en_rom_r     <= 1'b0;
            adrs_r       <= '0;
        end else begin
            en_rom_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    in_ready_r <= 1'b1;
                    if (bus.IN_VALID && in_ready_r) begin
                        in_ready_r   <= 1'b0;
                        shift_left_r <= dec_left;
                        if (dec_sat) begin
                            sat_r       <= 1'b1;
                            shift_amt_r <= {P{1'b1}};
                            out_valid_r <= 1'b1;
                            state       <= ST_HOLD;
                        end else begin
                            adrs_r   <= dec_adrs;
                            en_rom_r <= 1'b1;
                            state    <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    lat_cnt <= CNT_LOAD;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    // lat_cnt hits zero on the cycle LUT_D holds this lookup
                    if (lat_cnt == 2'd0) begin
                        shift_amt_r <= bus.LUT_D;
                        out_valid_r <= 1'b1;
                        state       <= ST_HOLD;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                ST_HOLD: begin
                    if (bus.OUT_READY) begin
                        out_valid_r <= 1'b0;
                        sat_r       <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.IN_READY   = in_ready_r;
    assign bus.OUT_VALID  = out_valid_r;
    assign bus.SHIFT_AMT  = shift_amt_r;
    assign bus.SHIFT_LEFT = shift_left_r;
    assign bus.SAT        = sat_r;
    assign bus.EN_ROM1    = en_rom_r;
    assign bus.ADRS       = adrs_r;
    assign state_dbg      = state;

endmodule

// File: tb/tb_shift_lut_sequencer.sv
// Bench for shift_lut_sequencer: two instances (ROM latency 1 and 3) driven
// one at a time, results compared with an exponent-rule reference model.
module tb_shift_lut_sequencer;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];

  logic       sel;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] exp_in;
  logic [1:0] st1, st3;

  shift_lut_sequencer_if #(.P(5), .EW(8)) if1 ();
  shift_lut_sequencer_if #(.P(5), .EW(8)) if3 ();

  assign if1.IN_VALID  = in_valid & ~sel;
  assign if3.IN_VALID  = in_valid & sel;
  assign if1.EXP       = exp_in;
  assign if3.EXP       = exp_in;
  assign if1.OUT_READY = out_ready & ~sel;
  assign if3.OUT_READY = out_ready & sel;

  shift_lut_sequencer #(.P(5), .EW(8), .BIAS(127), .LUT_LAT(1)) u_dut1 (
    .CLK       (clk),
    .RST       (rst_n),
    .bus       (if1),
    .state_dbg (st1)
  );

  shift_lut_sequencer #(.P(5), .EW(8), .BIAS(127), .LUT_LAT(3)) u_dut3 (
    .CLK       (clk),
    .RST       (rst_n),
    .bus       (if3),
    .state_dbg (st3)
  );

  // ROM model ROM[a] = a+1; junk on LUT_D whenever no lookup is due
  logic [4:0] d1, d2;
  logic       v1, v2;
  always @(posedge clk) begin
    if1.LUT_D <= if1.EN_ROM1 ? 5'(if1.ADRS + 5'd1)
                             : 5'(if1.ADRS + 5'd1) ^ 5'($urandom_range(1, 31));
    d1 <= 5'(if3.ADRS + 5'd1);
    v1 <= if3.EN_ROM1;
    d2 <= d1;
    v2 <= v1;
    if3.LUT_D <= v2 ? d2 : d2 ^ 5'($urandom_range(1, 31));
  end

  logic       o_in_ready, o_valid, o_left, o_sat, o_en;
  logic [4:0] o_amt, o_adrs;
  assign o_in_ready = sel ? if3.IN_READY   : if1.IN_READY;
  assign o_valid    = sel ? if3.OUT_VALID  : if1.OUT_VALID;
  assign o_left     = sel ? if3.SHIFT_LEFT : if1.SHIFT_LEFT;
  assign o_sat      = sel ? if3.SAT        : if1.SAT;
  assign o_en       = sel ? if3.EN_ROM1    : if1.EN_ROM1;
  assign o_amt      = sel ? if3.SHIFT_AMT  : if1.SHIFT_AMT;
  assign o_adrs     = sel ? if3.ADRS       : if1.ADRS;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (sel=%0d t=%0t)", tag, got, want, sel, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check(tag, {o_in_ready, o_valid, o_en, o_left, o_sat, o_adrs, o_amt}, 32'd0);
  endtask

  // driver: one transaction on the selected instance; hold = OUT_READY-low cycles
  task automatic run_txn(input logic [7:0] ev, input int hold, input bit poke);
    int         e, lat, cyc, en_cnt, en_cyc;
    logic [4:0] m_adrs, m_amt, en_adrs;
    logic       m_sat, m_left;
    logic [6:0] want;
    bit         got;
    e      = int'(ev) - 127;
    m_sat  = (e < -32) || (e > 31);
    m_left = m_sat ? (e > 0) : (e >= 0);
    m_adrs = 5'(e >= 0 ? e : -e - 1);
    m_amt  = m_sat ? 5'd31 : 5'((int'(m_adrs) + 1) % 32);
    lat    = m_sat ? 1 : 2 + (sel ? 3 : 1);
    exp_q.push_back({m_sat, m_left, m_amt});

    cyc = 0;
    while (!o_in_ready && cyc < 16) begin
      @(negedge clk);
      cyc++;
    end
    check("in_ready", o_in_ready, 1);
    in_valid  = 1'b1;
    exp_in    = ev;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_in   = 8'($urandom);

    got = 0; cyc = 0; en_cnt = 0; en_cyc = 0; en_adrs = 5'd0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (o_en) begin
        en_cnt++;
        en_cyc  = c;
        en_adrs = o_adrs;
      end
      if (o_valid) begin
        got = 1;
        cyc = c;
        break;
      end
    end
    check("valid_seen", got, 1);
    check("latency", cyc, lat);
    check("en_pulses", en_cnt, m_sat ? 1'b0 : 1'b1);
    want = exp_q.pop_front();
    check("result", {o_sat, o_left, o_amt}, want);
    if (!m_sat) begin
      check("en_cycle", en_cyc, 1);
      check("en_adrs", en_adrs, m_adrs);
      check("adrs", o_adrs, m_adrs);
    end

    for (int k = 0; k < hold; k++) begin
      if (poke) begin
        in_valid = 1'b1;
        exp_in   = 8'($urandom);
      end
      @(negedge clk);
      check("hold_valid", o_valid, 1);
      check("hold_result", {o_sat, o_left, o_amt}, want);
      check("hold_in_ready", o_in_ready, 0);
      check("hold_en", o_en, 0);
      if (!m_sat) check("hold_adrs", o_adrs, m_adrs);
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("idle_valid", o_valid, 0);
    check("idle_sat", o_sat, 0);
    check("idle_in_ready", o_in_ready, 1);
    check("idle_en", o_en, 0);
    if (!m_sat) check("idle_adrs", o_adrs, m_adrs);
  endtask

  logic [7:0] bnd [8] = '{8'd94, 8'd95, 8'd96, 8'd127, 8'd157, 8'd158, 8'd159, 8'd160};

  initial begin
    rst_n     = 1'b0;
    sel       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_in    = 8'd0;
    repeat (3) @(negedge clk);
    check_zero("reset_dut1");
    sel = 1'b1;
    #1;
    check_zero("reset_dut3");
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_in_ready", o_in_ready, 0);
    @(negedge clk);
    check("first_edge_in_ready", o_in_ready, 1);

    // directed cases on the latency-1 instance
    run_txn(8'd130, 0, 0);
    run_txn(8'd120, 0, 0);
    run_txn(8'd158, 0, 0);
    run_txn(8'd95,  0, 0);
    run_txn(8'd159, 0, 0);
    run_txn(8'd94,  0, 0);
    run_txn(8'd130, 5, 1);
    run_txn(8'd200, 3, 1);

    // reset while waiting on the ROM
    in_valid  = 1'b1;
    exp_in    = 8'd130;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("abort_outputs");
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_quiet", o_valid, 0);
    end
    run_txn(8'd127, 0, 0);

    // latency-3 instance
    sel = 1'b1;
    @(negedge clk);
    run_txn(8'd130, 0, 0);
    run_txn(8'd95,  0, 0);
    run_txn(8'd159, 0, 0);
    run_txn(8'd110, 4, 1);

    // randomized mix
    repeat (40) begin
      logic [7:0] ev;
      sel = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) ev = bnd[$urandom_range(0, 7)];
      else                           ev = 8'($urandom_range(0, 255));
      @(negedge clk);
      run_txn(ev, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
